// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The controller takes the master side; the datapath (or a bench) takes the slave side.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic [3:0] state;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output mem_req, pc_write, adr_src, mem_write, ir_write, reg_write,
        output result_src, alu_src_a, alu_src_b, imm_src, alu_control, state, illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  mem_req, pc_write, adr_src, mem_write, ir_write, reg_write,
        input  result_src, alu_src_a, alu_src_b, imm_src, alu_control, state, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control FSM (lw/sw/R/I/beq/jal) with memory wait states
// and an optional sticky trap on illegal opcodes.
module multicycle_controller #(
    parameter int ERROR_TRAP = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        ERROR    = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    state_t     state_q;
    state_t     state_d;
    logic       illegal_q;
    logic [1:0] alu_op;
    logic       pc_write_c;
    logic       ir_write_c;
    logic       reg_write_c;
    logic       mem_write_c;
    logic       mem_req_c;

    // Subtract only for R-type funct3=000 with funct7[5] set; I-type (op[5]=0) always adds.
    function automatic logic [2:0] alu_decode(input logic [1:0] aop, input logic [6:0] opc,
                                              input logic [2:0] f3, input logic f7b5);
        logic [2:0] res;
        res = 3'b000;
        case (aop)
            ALUOP_SUB: res = 3'b001;
            ALUOP_FUNCT: begin
                case (f3)
                    3'b000:  res = (opc[5] & f7b5) ? 3'b001 : 3'b000;
                    3'b010:  res = 3'b101;
                    3'b110:  res = 3'b011;
                    3'b111:  res = 3'b010;
                    default: res = 3'b000;
                endcase
            end
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    function automatic logic [1:0] imm_decode(input logic [6:0] opc);
        logic [1:0] res;
        res = 2'b00;
        case (opc)
            OP_STORE: res = 2'b01;
            OP_BEQ:   res = 2'b10;
            OP_JAL:   res = 2'b11;
            default:  res = 2'b00;
        endcase
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (bus.mem_ready) state_d = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECUTER;
                    OP_ITYPE:          state_d = EXECUTEI;
                    OP_BEQ:            state_d = BEQ;
                    OP_JAL:            state_d = JAL;
                    default:           state_d = (ERROR_TRAP != 0) ? ERROR : FETCH;
                endcase
            end
            MEMADR:   state_d = bus.op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (bus.mem_ready) state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: if (bus.mem_ready) state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            JAL:      state_d = FETCH;
            ERROR:    state_d = ERROR;
            default:  state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= (state_d == ERROR);
        end
    end

    // Per-state datapath controls; anything not set for a state stays 0.
    always_comb begin
        pc_write_c     = 1'b0;
        ir_write_c     = 1'b0;
        reg_write_c    = 1'b0;
        mem_write_c    = 1'b0;
        mem_req_c      = 1'b0;
        bus.adr_src    = 1'b0;
        bus.result_src = 2'b00;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        alu_op         = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                mem_req_c     = 1'b1;
                bus.alu_src_b = 2'b10;
                ir_write_c    = bus.mem_ready;
                pc_write_c    = bus.mem_ready;
            end
            DECODE: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
            end
            MEMADR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
            end
            MEMREAD: begin
                mem_req_c   = 1'b1;
                bus.adr_src = 1'b1;
            end
            MEMWB: begin
                bus.result_src = 2'b01;
                reg_write_c    = 1'b1;
            end
            MEMWRITE: begin
                mem_req_c   = 1'b1;
                bus.adr_src = 1'b1;
                mem_write_c = 1'b1;
            end
            EXECUTER: begin
                bus.alu_src_a = 2'b10;
                alu_op        = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                alu_op        = ALUOP_FUNCT;
            end
            ALUWB:    reg_write_c = 1'b1;
            BEQ: begin
                bus.alu_src_a = 2'b10;
                alu_op        = ALUOP_SUB;
                pc_write_c    = bus.zero;
            end
            JAL: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                pc_write_c    = 1'b1;
            end
            default: ;
        endcase
    end

    // Architectural write strobes are gated by reset so nothing commits while it is held.
    assign bus.pc_write    = rst & pc_write_c;
    assign bus.ir_write    = rst & ir_write_c;
    assign bus.reg_write   = rst & reg_write_c;
    assign bus.mem_write   = rst & mem_write_c;
    assign bus.mem_req     = rst & mem_req_c;
    assign bus.imm_src     = imm_decode(bus.op);
    assign bus.alu_control = alu_decode(alu_op, bus.op, bus.funct3, bus.funct7b5);
    assign bus.state       = state_q;
    assign bus.illegal     = illegal_q;
endmodule
